cache_request_arbiter: RTL and testbench

//  Shares the direct-mapped cache top between two requesters (port 0, port 1) with fair round-robin.

---
 rtl/cache_request_arbiter_pkg.sv | 16 +
 rtl/cache_request_arbiter_if.sv | 30 +++
 rtl/cache_request_arbiter_rr_picker.sv | 11 +
 rtl/cache_request_arbiter.sv | 124 ++++++++++++
 tb/tb_cache_request_arbiter.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/cache_request_arbiter_pkg.sv
// Shared types and default sizes for the two-port cache request arbiter.
package cache_request_arbiter_pkg;

  localparam int ADDR_W_DEF  = 15;
  localparam int LINE_W_DEF  = 128;
  localparam int TIMEOUT_DEF = 64;
  localparam int CNT_W_DEF   = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/cache_request_arbiter_if.sv
// Requester and cache-controller signals of the arbiter, bundled as one interface.
interface cache_request_arbiter_if #(
  parameter int ADDR_W = cache_request_arbiter_pkg::ADDR_W_DEF,
  parameter int LINE_W = cache_request_arbiter_pkg::LINE_W_DEF
);
  logic              req0;
  logic              req1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic              ack0;
  logic              ack1;
  logic              err0;
  logic              err1;
  logic [LINE_W-1:0] rdata;
  logic              cache_start;
  logic [ADDR_W-1:0] cache_address;
  logic              cache_done;
  logic [LINE_W-1:0] cache_memOut;
  logic              busy;

  modport slave (
    input  req0, req1, addr0, addr1, cache_done, cache_memOut,
    output ack0, ack1, err0, err1, rdata, cache_start, cache_address, busy
  );

  modport master (
    output req0, req1, addr0, addr1, cache_done, cache_memOut,
    input  ack0, ack1, err0, err1, rdata, cache_start, cache_address, busy
  );
endinterface

// File: rtl/cache_request_arbiter_rr_picker.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port not granted last.
module cache_rr_picker (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_grant_i,
  output logic valid_o,
  output logic gnt_id_o
);
  assign valid_o  = req0_i | req1_i;
  assign gnt_id_o = (req0_i & req1_i) ? ~last_grant_i : req1_i;
endmodule

// File: rtl/cache_request_arbiter.sv
// Round-robin front end for the direct-mapped cache: one lookup at a time,
// with a watchdog that aborts a lookup whose done never arrives.
module cache_request_arbiter
  import cache_request_arbiter_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int LINE_W  = LINE_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  cache_request_arbiter_if.slave  bus
);

  arb_state_e        state_q, state_d;
  logic              gnt_id_q, gnt_id_d;
  logic              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  logic [1:0]        ack_q, ack_d;
  logic [1:0]        err_q, err_d;
  logic              start_q, start_d;
  logic [CNT_W-1:0]  wd_q, wd_d;

  logic              pick_valid;
  logic              pick_gnt;
  logic [1:0]        port_hit;
  logic              wd_expired;

  cache_rr_picker u_picker (
    .req0_i       (bus.req0),
    .req1_i       (bus.req1),
    .last_grant_i (last_grant_q),
    .valid_o      (pick_valid),
    .gnt_id_o     (pick_gnt)
  );

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign port_hit[gi] = (gnt_id_q == 1'(gi));
  end

  assign wd_expired = (wd_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d      = state_q;
    gnt_id_d     = gnt_id_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    rdata_d      = rdata_q;
    wd_d         = wd_q;
    ack_d        = 2'b00;
    err_d        = 2'b00;
    start_d      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          gnt_id_d = pick_gnt;
          addr_d   = pick_gnt ? bus.addr1 : bus.addr0;
          start_d  = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wd_d    = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // done takes priority over an expiry on the same cycle
        if (bus.cache_done) begin
          rdata_d = bus.cache_memOut;
          ack_d   = port_hit;
          state_d = ST_RESP;
        end else if (wd_expired) begin
          rdata_d = '0;
          ack_d   = port_hit;
          err_d   = port_hit;
          state_d = ST_RESP;
        end else begin
          wd_d = wd_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        last_grant_d = gnt_id_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      gnt_id_q     <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      rdata_q      <= '0;
      ack_q        <= 2'b00;
      err_q        <= 2'b00;
      start_q      <= 1'b0;
      wd_q         <= '0;
    end else begin
      state_q      <= state_d;
      gnt_id_q     <= gnt_id_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      rdata_q      <= rdata_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      start_q      <= start_d;
      wd_q         <= wd_d;
    end
  end

  assign bus.ack0          = ack_q[0];
  assign bus.ack1          = ack_q[1];
  assign bus.err0          = err_q[0];
  assign bus.err1          = err_q[1];
  assign bus.rdata         = rdata_q;
  assign bus.cache_start   = start_q;
  assign bus.cache_address = addr_q;
  assign bus.busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cache_request_arbiter.sv
// Directed bench for cache_request_arbiter: a table of lookups plus hand-written reset/stale-done sequences.
module tb_cache_request_arbiter;

  localparam int AW = 15;
  localparam int LW = 128;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cache_request_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

  cache_request_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(TO), .CNT_W(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string           name;
    bit              pre_rst;
    logic            r0;
    logic            r1;
    logic [AW-1:0]   a0;
    logic [AW-1:0]   a1;
    int              done_dly;   // WAIT cycle carrying done; 0 = never
    bit              stale;      // also pulse done during ISSUE
    logic [LW-1:0]   mem;
    int              exp_gnt;
    logic            exp_err;
    logic [LW-1:0]   exp_rdata;
    int              exp_lat;    // cycles from start to ack
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  task automatic check(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic check_reset_state(input string nm);
    check({nm, "_rst_busy"},  LW'(bus.busy), '0);
    check({nm, "_rst_start"}, LW'(bus.cache_start), '0);
    check({nm, "_rst_ack"},   LW'({bus.ack1, bus.ack0}), '0);
    check({nm, "_rst_err"},   LW'({bus.err1, bus.err0}), '0);
    check({nm, "_rst_rdata"}, bus.rdata, '0);
    check({nm, "_rst_addr"},  LW'(bus.cache_address), '0);
  endtask

  // Called at a negedge; the request levels take effect in the next IDLE cycle.
  task automatic run_vec(input vec_t v);
    bit            got;
    int            early;
    int            start_cyc;
    int            lat;
    logic [AW-1:0] exp_addr;
    logic [1:0]    mask;
    if (v.pre_rst) begin
      rst = 1'b1;
      @(negedge clk);
      check_reset_state(v.name);
      @(negedge clk);
      rst = 1'b0;
    end
    bus.req0  = v.r0;
    bus.req1  = v.r1;
    bus.addr0 = v.a0;
    bus.addr1 = v.a1;
    exp_addr  = (v.exp_gnt == 1) ? v.a1 : v.a0;
    mask      = (v.exp_gnt == 1) ? 2'b10 : 2'b01;
    got = 1'b0;
    early = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (bus.cache_start) got = 1'b1;
      else if (bus.ack0 || bus.ack1) early++;
    end
    if (!got) begin
      $display("FAIL %s_start: got no cache_start expected one within 8 cycles", v.name);
      total_cnt++;
      return;
    end
    start_cyc = cyc;
    check({v.name, "_early_ack"}, LW'(early), '0);
    check({v.name, "_busy"}, LW'(bus.busy), LW'(1));
    check({v.name, "_addr"}, LW'(bus.cache_address), LW'(exp_addr));
    bus.addr0 = ~v.a0;
    bus.addr1 = ~v.a1;
    bus.cache_memOut = ~v.exp_rdata;
    if (v.stale) bus.cache_done = 1'b1;
    got = 1'b0;
    for (int i = 1; i <= TO + 8 && !got; i++) begin
      @(negedge clk);
      bus.cache_done = 1'b0;
      if (bus.ack0 || bus.ack1) got = 1'b1;
      else if (i == v.done_dly) begin
        bus.cache_done   = 1'b1;
        bus.cache_memOut = v.mem;
      end
    end
    if (!got) begin
      $display("FAIL %s_ack: got no ack expected one within %0d cycles", v.name, TO + 8);
      total_cnt++;
      return;
    end
    lat = cyc - start_cyc;
    check({v.name, "_ack"},   LW'({bus.ack1, bus.ack0}), LW'(mask));
    check({v.name, "_err"},   LW'({bus.err1, bus.err0}), v.exp_err ? LW'(mask) : '0);
    check({v.name, "_rdata"}, bus.rdata, v.exp_rdata);
    check({v.name, "_lat"},   LW'(lat), LW'(v.exp_lat));
    check({v.name, "_addr_hold"}, LW'(bus.cache_address), LW'(exp_addr));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish before 2ms");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [LW-1:0] m1, m2, m3, m4, m5, m6, m7, m8, m9, a5, ones;
    vec_t          v;
    int            bad;
    m1 = 128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff;
    m2 = 128'h1111_0000_2222_0000_3333_0000_4444_0000;
    m3 = 128'hdead_beef_0000_0001_cafe_f00d_0000_0002;
    m4 = 128'h0f0f_0f0f_f0f0_f0f0_1234_5678_9abc_def0;
    m5 = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
    m6 = 128'h7777_6666_5555_4444_3333_2222_1111_0000;
    m7 = 128'h0000_0000_0000_0000_0000_0000_0bad_f00d;
    m8 = 128'hfeed_face_0123_4567_89ab_cdef_0000_ffff;
    m9 = 128'h5a5a_5a5a_5a5a_5a5a_5a5a_5a5a_5a5a_5a5a;
    a5 = {16{8'ha5}};
    ones = '1;

    bus.req0 = 1'b0;  bus.req1 = 1'b0;
    bus.addr0 = '0;   bus.addr1 = '0;
    bus.cache_done = 1'b0;
    bus.cache_memOut = '0;

    //         name        rst r0 r1  a0        a1        dly stale mem gnt err rdata lat
    vecs[0] = '{"t1_single", 1, 1, 0, 15'h0123, 15'h0000, 2,  0, m1, 0, 0, m1, 3};
    vecs[1] = '{"t2_tie_a",  1, 1, 1, 15'h0456, 15'h0789, 1,  0, m2, 0, 0, m2, 2};
    vecs[2] = '{"t2_tie_b",  0, 1, 1, 15'h0456, 15'h0789, 1,  0, m3, 1, 0, m3, 2};
    vecs[3] = '{"t2_tie_c",  0, 1, 1, 15'h0456, 15'h0789, 1,  0, m4, 0, 0, m4, 2};
    vecs[4] = '{"t2_tie_d",  0, 1, 1, 15'h0456, 15'h0789, 1,  0, m5, 1, 0, m5, 2};
    vecs[5] = '{"t3_tmo",    0, 0, 1, 15'h0000, 15'h7fff, 0,  0, m6, 1, 1, '0, 65};
    vecs[6] = '{"t3_after",  0, 0, 1, 15'h0000, 15'h0001, 3,  0, m7, 1, 0, m7, 4};
    vecs[7] = '{"t6_edge",   0, 1, 0, 15'h5555, 15'h0000, 64, 0, a5, 0, 0, a5, 65};
    vecs[8] = '{"t4_stale",  0, 0, 1, 15'h0000, 15'h0abc, 3,  1, m8, 1, 0, m8, 4};
    vecs[9] = '{"tie_after", 0, 1, 1, 15'h1357, 15'h2468, 1,  0, m9, 0, 0, m9, 2};

    @(negedge clk);
    for (int k = 0; k < NV; k++) run_vec(vecs[k]);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;

    // Reset in the middle of a port-0 WAIT: nothing completes, port 1 then served.
    @(negedge clk);
    bus.req0 = 1'b1;
    bus.addr0 = 15'h2222;
    bad = 1;
    for (int i = 0; i < 8 && bad == 1; i++) begin
      @(negedge clk);
      if (bus.cache_start) bad = 0;
    end
    check("t5_start_seen", LW'(bad), '0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_async_busy",  LW'(bus.busy), '0);
    check("t5_async_start", LW'(bus.cache_start), '0);
    check("t5_async_ack",   LW'({bus.ack1, bus.ack0}), '0);
    bus.req0 = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.ack0 || bus.ack1 || bus.err0 || bus.err1) bad++;
    end
    check("t5_no_ack_in_rst", LW'(bad), '0);
    rst = 1'b0;
    v = '{"t5_post", 0, 0, 1, 15'h0000, 15'h3333, 1, 0, m3, 1, 0, m3, 2};
    run_vec(v);
    bus.req1 = 1'b0;

    // Stray done while IDLE must not start or complete anything.
    @(negedge clk);
    @(negedge clk);
    bus.cache_done = 1'b1;
    bus.cache_memOut = ones;
    @(negedge clk);
    bus.cache_done = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.busy || bus.ack0 || bus.ack1 || bus.cache_start) bad++;
    end
    check("t4_idle_done", LW'(bad), '0);
    check("t4_idle_rdata", bus.rdata, m3);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
